// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes (common with the decoder),
// execute-stage FSM states and the shift-amount width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int SHAMT_W   = $clog2(ALU_WIDTH);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-cycle shifter: accumulator plus a down-counter of remaining steps.
// next_o is the accumulator after this cycle's shift, so the caller can capture it on the last step.
module serial_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic             arith,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic [WIDTH-1:0] next_o,
  output logic             last_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             fill;

  // The sra fill is the accumulator MSB, which still equals the loaded A[WIDTH-1].
  always_comb begin
    fill = arith ? acc_q[WIDTH-1] : 1'b0;
    if (dir) begin
      next_o = {fill, acc_q[WIDTH-1:1]};
    end else begin
      next_o = {acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = data_i;
      cnt_d = shamt_i;
    end else if (en) begin
      acc_d = next_o;
      cnt_d = cnt_q - SHW'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == SHW'(1));

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle logic/arithmetic/compare ops and serial shifts.
// ready/done/ZeroE are decoded from registers only; the result holds until the next completion.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControlE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALUResultE,
  output logic             ZeroE
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sh_next;
  logic [SHW-1:0]   shamt;
  logic             sh_load, sh_en, sh_last;

  assign shamt = SrcBE[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      ALU_ADD:  alu_res = SrcAE + SrcBE;
      ALU_SUB:  alu_res = SrcAE - SrcBE;
      ALU_AND:  alu_res = SrcAE & SrcBE;
      ALU_OR:   alu_res = SrcAE | SrcBE;
      ALU_XOR:  alu_res = SrcAE ^ SrcBE;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (SrcAE < SrcBE)};
      default:  alu_res = '0;
    endcase
  end

  // A start is only honoured outside SHIFT; shamt=0 shifts complete like single-cycle ops.
  always_comb begin
    state_d  = ST_IDLE;
    result_d = result_q;
    op_d     = op_q;
    sh_load  = 1'b0;
    sh_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (is_shift(ALUControlE)) begin
            if (shamt == '0) begin
              result_d = SrcAE;
              state_d  = ST_DONE;
            end else begin
              sh_load = 1'b1;
              op_d    = ALUControlE;
              state_d = ST_SHIFT;
            end
          end else begin
            result_d = alu_res;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_en = 1'b1;
        if (sh_last) begin
          result_d = sh_next;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      op_q     <= 4'b0000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      op_q     <= op_d;
    end
  end

  serial_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load   (sh_load),
    .en     (sh_en),
    .dir    (op_q != ALU_SLL),
    .arith  (op_q == ALU_SRA),
    .data_i (SrcAE),
    .shamt_i(shamt),
    .next_o (sh_next),
    .last_o (sh_last)
  );

  assign ready      = (state_q != ST_SHIFT);
  assign done       = (state_q == ST_DONE);
  assign ALUResultE = result_q;
  assign ZeroE      = (result_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu against a cycle-level behavioural model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  ALUControlE;
  logic [31:0] SrcAE, SrcBE;
  logic        ready, done, ZeroE;
  logic [31:0] ALUResultE;

  int errors = 0;
  int checks = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUControlE(ALUControlE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ready(ready), .done(done),
    .ALUResultE(ALUResultE), .ZeroE(ZeroE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_val(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh = b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return $signed(a) >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    if (op >= 4'd7 && op <= 4'd9 && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  int          cycle = 0;
  bit          pend = 0;
  int          done_cyc = 0;
  logic [31:0] pend_res = 32'd0;
  logic [31:0] held = 32'd0;
  bit          done_now = 0;

  // Model advances once per clock: acceptance uses its own notion of ready.
  always @(posedge clk) begin
    if (reset) begin
      pend = 0;
      held = 32'd0;
    end else if (start && !(pend && cycle < done_cyc)) begin
      pend     = 1;
      done_cyc = cycle + model_lat(ALUControlE, SrcBE);
      pend_res = model_val(ALUControlE, SrcAE, SrcBE);
    end
    cycle++;
    done_now = pend && (cycle == done_cyc);
    if (done_now) held = pend_res;
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    chk("ready", {31'd0, ready}, {31'd0, !(pend && cycle < done_cyc)});
    chk("done", {31'd0, done}, {31'd0, done_now});
    chk("zero", {31'd0, ZeroE}, {31'd0, (held == 32'd0)});
    if (done_now) chk("result", ALUResultE, held);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; ALUControlE = op; SrcAE = a; SrcBE = b;
    tick();
    start = 1'b0; ALUControlE = 4'd0; SrcAE = 32'hDEAD_BEEF; SrcBE = 32'h0000_0003;
  endtask

  // Returns latency in cycles and number of cycles ready was low before done.
  task automatic wait_done(output int lat, output int low);
    lat = 1; low = 0;
    while (!done && lat < 40) begin
      if (!ready) low++;
      tick(); lat++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, low;
    tick();
    wait_ready();
    issue(op, a, b);
    wait_done(lat, low);
    chk({name, "_val"}, ALUResultE, exp);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_zero"}, {31'd0, ZeroE}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    int lat, low, ndone;
    logic [3:0] op;
    reset = 1'b1; start = 1'b0; ALUControlE = 4'd0; SrcAE = 32'd0; SrcBE = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", ALUResultE, 32'd0);
    chk("rst_zero", {31'd0, ZeroE}, 32'd1);

    // add then back-to-back sub in the DONE cycle
    tick();
    issue(4'd0, 32'd5, 32'd7);
    chk("add_done", {31'd0, done}, 32'd1);
    chk("add_val", ALUResultE, 32'd12);
    chk("add_zero", {31'd0, ZeroE}, 32'd0);
    issue(4'd1, 32'd9, 32'd4);
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_val", ALUResultE, 32'd5);

    run("sub0", 4'd1, 32'd3, 32'd3, 32'd0, 1);
    run("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
    run("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    run("addwrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1);
    run("illegal", 4'hF, 32'd123, 32'd456, 32'd0, 1);

    // sll by 31: ready low 31 cycles
    tick();
    issue(4'd7, 32'd1, 32'd31);
    wait_done(lat, low);
    chk("sll31_val", ALUResultE, 32'h8000_0000);
    chk("sll31_lat", lat, 32);
    chk("sll31_low", low, 31);

    run("sll0", 4'd7, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1);
    run("sra4", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
    run("srl4", 4'd8, 32'h8000_0000, 32'd4, 32'h0800_0000, 5);

    // start pulsed mid-shift is ignored
    tick();
    issue(4'd9, 32'h8000_0000, 32'd8);
    tick();
    start = 1'b1; ALUControlE = 4'd0; SrcAE = 32'd1; SrcBE = 32'd1;
    tick();
    start = 1'b0;
    wait_done(lat, low);
    chk("midstart_val", ALUResultE, 32'hFF80_0000);
    chk("midstart_lat", lat + 2, 9);
    tick();
    chk("midstart_noextra", {31'd0, done}, 32'd0);

    // reset on the 3rd shift cycle of sll by 10
    tick();
    issue(4'd7, 32'd3, 32'd10);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("rst_mid_nodone", ndone, 0);
    chk("rst_mid_ready", {31'd0, ready}, 32'd1);
    chk("rst_mid_result", ALUResultE, 32'd0);
    chk("rst_mid_zero", {31'd0, ZeroE}, 32'd1);

    // start coincident with reset is dropped
    reset = 1'b1; start = 1'b1; ALUControlE = 4'd0; SrcAE = 32'd4; SrcBE = 32'd4;
    tick();
    reset = 1'b0; start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("rst_start_nodone", ndone, 0);

    // random ops, checked by the compare process
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 11));
      if (op > 4'd9) op = 4'hA + 4'($urandom_range(0, 5));
      wait_ready();
      issue(op, $urandom, $urandom);
      wait_done(lat, low);
      if ($urandom_range(0, 2) == 0) tick();
    end
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Execute-stage ALU that consumes the 4-bit ALUControl code produced by the ALU decoder and computes the result. Logic/arithmetic/compare ops complete in one cycle. Shifts run through a one-bit-per-cycle serial shifter. The block sits between the ID/EX pipeline register and the EX/MEM register; its `ready` feeds the hazard unit, which stalls the front end while a shift is in flight.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; shift amount is `$clog2(WIDTH)` bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `ALUControlE`  in  4  operation code, sampled with `start`.
- `SrcAE`  in  WIDTH  operand A, sampled with `start`.
- `SrcBE`  in  WIDTH  operand B, sampled with `start`; for shifts only `SrcBE[4:0]` is used (shamt).
- `ready`  out  1  block can accept `start` this cycle.
- `done`  out  1  one-cycle pulse: `ALUResultE` is newly valid.
- `ALUResultE`  out  WIDTH  registered result; holds until the next completion.
- `ZeroE`  out  1  `ALUResultE == 0`, derived combinationally from the result register.

## Operation
- Code map: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- Codes 1010–1111 are illegal: result 0, single-cycle completion.
- Add and sub wrap modulo 2^WIDTH.
- slt and sltu return a zero-extended 0 or 1.
- FSM states:
  - IDLE (reset state).
  - SHIFT.
  - DONE.
- `ready` = state≠SHIFT.
- `done` = (state==DONE).
- Transitions from IDLE or DONE:
  - No `start`: go to IDLE.
  - `start` with a non-shift op: compute, load the result register, go to DONE.
  - `start` with a shift op and shamt=0: load A into the result register, go to DONE.
  - `start` with a shift op and shamt=k>0: load A into the shift accumulator, set count=k, go to SHIFT.
- SHIFT, every cycle: shift the accumulator by 1 and decrement count.
  - Fill bit is 0 for sll and srl, and A[WIDTH-1] for sra.
  - On the cycle where count==1, write the shifted value into the result register and go to DONE.
- `start` while in SHIFT is ignored: no queueing, no effect on the in-flight op.
- `ALUResultE` changes only when entering DONE or on reset.
- Reset:
  - State goes to IDLE, result register to 0, count and accumulator to 0.
  - Outputs after reset: `ready`=1, `done`=0, `ALUResultE`=0, `ZeroE`=1.
- Reset mid-shift: the op is abandoned, with no `done` pulse.
- Reset asserted in the same cycle as `start`: reset wins, and the `start` is dropped.

## Timing
- Let N be the cycle in which `start` is accepted.
- Non-shift op, or shift with shamt=0:
  - `done`=1 and result valid in cycle N+1.
  - Throughput is 1 op/cycle, because a `start` in the DONE cycle is accepted.
- Shift with shamt=k>0:
  - `ready`=0 in cycles N+1 … N+k.
  - `done`=1 in cycle N+k+1.
  - Worst case is k=31: `done` at N+32.
- Operands and code are captured only at acceptance; input changes after cycle N have no effect.
- No combinational path from inputs to any output. `ready`, `done` and `ZeroE` come from registers or from logic on registers only.

## Structure
- Shared package `alu_pkg`:
  - ALUControl code localparams/enum (shared with the decoder).
  - FSM state enum.
  - `SHAMT_W`.
- One sub-module, `serial_shifter`:
  - Inputs: `load`, `en`, `dir` (left/right), `arith`, data in.
  - Holds the accumulator and the down-counter; outputs `last` (count==1).
- `seq_alu` holds the FSM, the single-cycle datapath, the result register and the mux into it.

## Test plan
- Add 5+7 at N → `done`=1 at N+1, `ALUResultE`=12, `ZeroE`=0. Back-to-back `start` sub 9−4 in the DONE cycle → 5 at N+2.
- Sub 3−3 → 0 with `ZeroE`=1. slt 0xFFFFFFFF vs 1 → 1. sltu 0xFFFFFFFF vs 1 → 0. Illegal code 1111 → 0, `done` at N+1.
- sll 0x1 by 31 → `ready` low for 31 cycles, `done` at N+32, result 0x80000000. sll by shamt 0 (`SrcBE`=0x20) → result A, `done` at N+1.
- sra 0x80000000 by 4 → 0xF8000000. srl of the same → 0x08000000. A `start` add pulsed mid-shift is ignored, and the result is unchanged.
- Reset asserted on the 3rd cycle of an sll-by-10 → no `done` ever. After reset: `ready`=1, `ALUResultE`=0, `ZeroE`=1. A `start` coincident with reset produces no `done`.
- Randomized ops against a reference model across all 10 legal codes: every `done` matches the expected value and latency, and `done` never appears without an accepted `start`.
